// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule types, constants and the round-constant table.
package aes_key_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Round constant for step rc, placed in the top byte of the word.
    function automatic word_t rcon(input logic [3:0] rc);
        logic [7:0] b;
        case (rc)
            4'd0:    b = 8'h01;
            4'd1:    b = 8'h02;
            4'd2:    b = 8'h04;
            4'd3:    b = 8'h08;
            4'd4:    b = 8'h10;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h40;
            4'd7:    b = 8'h80;
            4'd8:    b = 8'h1b;
            4'd9:    b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/inv_key_round.sv
// Inverse AES-128 key expansion step: key of round rc+1 -> key of round rc.
module inv_key_round
    import aes_key_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   rc,
    output logic [127:0] prev_key
);

    word_t n0, n1, n2, n3;
    word_t w1, w2, w3;
    word_t rot, sub;

    assign {n0, n1, n2, n3} = key;

    // The three trailing words fall out of adjacent XORs; w3 then feeds the S-boxes.
    assign w3 = n3 ^ n2;
    assign w2 = n2 ^ n1;
    assign w1 = n1 ^ n0;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign prev_key = {n0 ^ sub ^ rcon(rc), w1, w2, w3};

endmodule

// File: rtl/keyGen.sv
// Forward AES-128 single-round key expansion: key of round rc -> key of round rc+1.
module keyGen
    import aes_key_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    word_t w0, w1, w2, w3;
    word_t n0, n1, n2, n3;
    word_t rot, sub;

    assign {w0, w1, w2, w3} = key_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign n0 = w0 ^ sub ^ rcon(rc);
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte of the table.
    assign y = SBOX_TBL[(255 - int'(a)) * 8 +: 8];

endmodule

// File: rtl/key_sched_inv.sv
// AES-128 inverse key schedule: streams round keys 10 down to 0 over valid/ready.
module key_sched_inv
    import aes_key_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_key_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         key_type,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         last
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("key_sched_inv supports only NUM_ROUNDS = 10 (AES-128)");
    end

    localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] TOP_RND = 4'(NUM_ROUNDS);

    state_t     state, state_nx;
    key_t       key_reg;
    logic [3:0] round_q;   // rc while in FWD, round index while in EMIT
    key_t       fwd_key, inv_key;

    keyGen u_keygen (
        .rc      (round_q),
        .key_in  (key_reg),
        .key_out (fwd_key)
    );

    inv_key_round u_inv (
        .key      (key_reg),
        .rc       (round_q - 4'd1),
        .prev_key (inv_key)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode: load, forward expansion to round 10, then reverse emission.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = key_type ? FWD : EMIT;
            FWD:     if (round_q == LAST_RC) state_nx = EMIT;
            EMIT:    if (out_ready && round_q == 4'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Key register and round counter; after the rc=9 step the counter lands on 10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            round_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key_reg <= key_in;
                    round_q <= key_type ? 4'd0 : TOP_RND;
                end
                FWD: begin
                    key_reg <= fwd_key;
                    round_q <= round_q + 4'd1;
                end
                EMIT: if (out_ready && round_q != 4'd0) begin
                    key_reg <= inv_key;
                    round_q <= round_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign last      = (state == EMIT) && (round_q == 4'd0);
    assign key_out   = key_reg;
    assign round_out = round_q;

endmodule

// File: tb/tb_key_sched_inv.sv
// Bench for key_sched_inv: FIPS-197 golden schedule plus randomized keys against a GF(2^8) model.
module tb_key_sched_inv;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         key_type;
    logic [127:0] key_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         last;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_keys [11];

    key_sched_inv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_type  (key_type),
        .key_in    (key_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_out   (key_out),
        .round_out (round_out),
        .last      (last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           rnd;
        logic [127:0] key;
    } rk_t;

    typedef struct {
        logic         kt;
        logic [127:0] kin;
        int           lat;
        bit           rnd_ready;
        int           hold_rnd;
        bit           poke;
    } case_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: AES key expansion from GF(2^8) arithmetic
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers (entered and left on a falling edge)
    task automatic launch(input logic kt, input logic [127:0] kin, input int lat);
        int n;
        start = 1'b1; key_type = kt; key_in = kin; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; key_type = 1'($urandom); key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_start", 128'(busy), 128'(1));
        n = 1;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", 128'(n), 128'(lat));
    endtask

    task automatic drain(input bit rnd_ready, input int hold_rnd, input bit poke);
        int idx = 10;
        int cyc = 0;
        int held = 0;
        bit rdy;
        while (idx >= 0 && cyc < 400 && out_valid) begin
            chk("beat_busy", 128'(busy), 128'(1));
            chk("beat_round", 128'(round_out), 128'(idx));
            chk("beat_key", key_out, exp_keys[idx]);
            chk("beat_last", 128'(last), 128'(idx == 0));
            rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (idx == hold_rnd && held < 5) begin
                rdy = 1'b0;
                held++;
            end
            out_ready = rdy;
            start = poke && (idx == 6 || (idx == 0 && rdy));
            if (start) begin
                key_type = 1'($urandom);
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
            if (rdy) idx--;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("stream_complete", 128'(idx < 0), 128'(1));
        chk("busy_after_last", 128'(busy), 128'(0));
        chk("valid_after_last", 128'(out_valid), 128'(0));
        chk("last_after_last", 128'(last), 128'(0));
    endtask

    // ---------------- tables
    rk_t golden [11];
    case_t cases [5];

    initial begin
        logic [127:0] ck;
        logic         kt;
        int           cyc;

        golden[0]  = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        golden[1]  = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        golden[2]  = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
        golden[3]  = '{3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        golden[4]  = '{4,  128'hef44a541a8525b7fb671253bdb0bad00};
        golden[5]  = '{5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        golden[6]  = '{6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        golden[7]  = '{7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        golden[8]  = '{8,  128'head27321b58dbad2312bf5607f8d292f};
        golden[9]  = '{9,  128'hac7766f319fadc2128d12941575c006e};
        golden[10] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        // forward load, direct load, backpressure at round 9, start while busy,
        // then an immediate restart with random ready and a hold
        cases[0] = '{1'b1, golden[0].key,  11, 1'b0, -1, 1'b0};
        cases[1] = '{1'b0, golden[10].key, 1,  1'b0, -1, 1'b0};
        cases[2] = '{1'b0, golden[10].key, 1,  1'b0, 9,  1'b0};
        cases[3] = '{1'b1, golden[0].key,  11, 1'b0, -1, 1'b1};
        cases[4] = '{1'b0, golden[10].key, 1,  1'b1, 9,  1'b0};

        rst_n = 1'b0; start = 1'b0; key_type = 1'b0; key_in = '0; out_ready = 1'b0;
        #2;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_last", 128'(last), 128'(0));
        chk("reset_key", key_out, 128'(0));
        chk("reset_round", 128'(round_out), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 11; r++) exp_keys[golden[r].rnd] = golden[r].key;
        for (int c = 0; c < 5; c++) begin
            launch(cases[c].kt, cases[c].kin, cases[c].lat);
            drain(cases[c].rnd_ready, cases[c].hold_rnd, cases[c].poke);
        end

        // Asynchronous reset in the middle of a stream, then a full restart.
        launch(1'b0, golden[10].key, 1);
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && round_out == 4'd5) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_round5", 128'(round_out), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(out_valid), 128'(0));
        chk("abort_last", 128'(last), 128'(0));
        chk("abort_key", key_out, 128'(0));
        chk("abort_round", 128'(round_out), 128'(0));
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1'b1, golden[0].key, 11);
        drain(1'b0, -1, 1'b0);

        // Randomized keys against the model.
        for (int t = 0; t < 6; t++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            kt = 1'($urandom);
            expand(ck);
            launch(kt, kt ? ck : exp_keys[10], kt ? 11 : 1);
            drain(1'b1, int'($urandom_range(0, 10)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
